// File: rtl/sub64_iterative_pkg.sv
// arith_pkg: shared constants for the iterative slice-serial arithmetic blocks.
//   - FSM state encodings (IDLE/RUN/DONE)
//   - default width / slice size and the derived slice count and counter width
//   - num_slices(): slice count for a given operand width and slice size
package arith_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int N_DEFAULT     = 64;
  localparam int SLICE_DEFAULT = 16;
  localparam int NUM_SLICES    = N_DEFAULT / SLICE_DEFAULT;
  localparam int CNT_W         = $clog2(NUM_SLICES);

  function automatic int num_slices(input int n, input int s);
    return n / s;
  endfunction

endpackage

// File: rtl/sub64_iterative_bla.sv
// Combinational borrow-lookahead subtractor slice and its building blocks.
//
// cla4_cell   : 4-bit carry-lookahead adder cell (sum, group P/G).
// cla_cgen4   : 4-group carry generator (carry into each group + carry out).
// sub_slice_bla:
//   a, b  [SLICE] in  : slice operands
//   bin         in  : incoming borrow
//   d     [SLICE] out : a - b - bin (mod 2^SLICE)
//   bout        out : outgoing borrow
//   p_o, g_o    out : slice propagate/generate in the a + ~b carry domain
// Subtraction is done as a + ~b + ~bin, so borrow = ~carry.

module cla4_cell (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       pg,
  output logic       gg
);
  logic [3:0] p, g, c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign s  = p ^ c;
  assign pg = &p;
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
endmodule

module cla_cgen4 (
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       cin,
  output logic [3:0] c,
  output logic       cout
);
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);
endmodule

module sub_slice_bla #(
  parameter int SLICE = 16
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             bin,
  output logic [SLICE-1:0] d,
  output logic             bout,
  output logic             p_o,
  output logic             g_o
);
  localparam int NG  = SLICE / 4;   // 4-bit groups
  localparam int NB4 = NG / 4;      // full 4-group lookahead blocks
  localparam int REM = NG % 4;      // leftover groups past the last full block

  logic [SLICE-1:0] bn;
  logic [NG-1:0]    gp, gg, gc;
  logic [NB4:0]     bc;             // carry between lookahead blocks
  logic             cout;

  assign bn    = ~b;
  assign bc[0] = ~bin;

  for (genvar i = 0; i < NG; i++) begin : g_grp
    cla4_cell u_cell (
      .a  (a[4*i +: 4]),
      .b  (bn[4*i +: 4]),
      .cin(gc[i]),
      .s  (d[4*i +: 4]),
      .pg (gp[i]),
      .gg (gg[i])
    );
  end

  for (genvar j = 0; j < NB4; j++) begin : g_blk
    cla_cgen4 u_cgen (
      .p   (gp[4*j +: 4]),
      .g   (gg[4*j +: 4]),
      .cin (bc[j]),
      .c   (gc[4*j +: 4]),
      .cout(bc[j+1])
    );
  end

  // Groups beyond the last full block chain on group P/G directly.
  if (REM == 0) begin : g_nrem
    assign cout = bc[NB4];
  end else begin : g_rem
    for (genvar i = NB4*4; i < NG; i++) begin : g_r
      if (i == NB4*4) begin : g_first
        assign gc[i] = bc[NB4];
      end else begin : g_next
        assign gc[i] = gg[i-1] | (gp[i-1] & gc[i-1]);
      end
    end
    assign cout = gg[NG-1] | (gp[NG-1] & gc[NG-1]);
  end

  assign bout = ~cout;
  assign p_o  = &gp;

  always_comb begin
    g_o = 1'b0;
    for (int i = 0; i < NG; i++) g_o = gg[i] | (gp[i] & g_o);
  end
endmodule

// File: rtl/sub64_iterative.sv
// sub64_iterative: multi-cycle unsigned N-bit subtractor, one SLICE per clock.
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : operand handshake (in_ready decoded from IDLE)
//   A, B, borrow_in     : minuend, subtrahend, incoming borrow
//   out_valid/out_ready : result handshake
//   D                   : A - B - borrow_in mod 2^N
//   borrow_out          : A < B + borrow_in
//   zero                : D == 0
//   overflow            : two's-complement overflow of the subtraction
// Latency: result valid N/SLICE cycles after the accept edge.

module sub64_iterative
  import arith_pkg::*;
#(
  parameter int N     = 64,
  parameter int SLICE = SLICE_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         borrow_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] D,
  output logic         borrow_out,
  output logic         zero,
  output logic         overflow
);
  localparam int NS = num_slices(N, SLICE);
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NS - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  a_q, b_q, d_q;
  logic          brw_q, zacc_q;
  logic          bo_q, z_q, ov_q, outv_q;

  logic [SLICE-1:0] a_sl, b_sl, sl_d;
  logic             sl_bout, sl_p, sl_g, sl_zero, last;

  assign a_sl    = a_q[int'(cnt_q)*SLICE +: SLICE];
  assign b_sl    = b_q[int'(cnt_q)*SLICE +: SLICE];
  assign last    = (cnt_q == LAST);
  assign sl_zero = ~|sl_d;

  sub_slice_bla #(.SLICE(SLICE)) u_slice (
    .a   (a_sl),
    .b   (b_sl),
    .bin (brw_q),
    .d   (sl_d),
    .bout(sl_bout),
    .p_o (sl_p),
    .g_o (sl_g)
  );

  // Slice borrow must agree with its own group propagate/generate summary.
  always_comb begin
    if (state_q == S_RUN) assert (sl_bout == ~(sl_g | (sl_p & ~brw_q)));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
      S_RUN: begin
        cnt_d = last ? '0 : cnt_q + 1'b1;
        if (last) state_d = S_DONE;
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      brw_q   <= 1'b0;
      zacc_q  <= 1'b0;
      bo_q    <= 1'b0;
      z_q     <= 1'b0;
      ov_q    <= 1'b0;
      outv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      case (state_q)
        S_IDLE: if (in_valid) begin
          a_q    <= A;
          b_q    <= B;
          brw_q  <= borrow_in;
          zacc_q <= 1'b1;
        end
        S_RUN: begin
          d_q[int'(cnt_q)*SLICE +: SLICE] <= sl_d;
          brw_q  <= sl_bout;
          zacc_q <= zacc_q & sl_zero;
          if (last) begin
            bo_q   <= sl_bout;
            z_q    <= zacc_q & sl_zero;
            // Sign bits live in the top slice, which is the one computed now.
            ov_q   <= (a_sl[SLICE-1] ^ b_sl[SLICE-1]) & (sl_d[SLICE-1] ^ a_sl[SLICE-1]);
            outv_q <= 1'b1;
          end
        end
        S_DONE: if (out_ready) outv_q <= 1'b0;
        default: outv_q <= 1'b0;
      endcase
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = outv_q;
  assign D          = d_q;
  assign borrow_out = bo_q;
  assign zero       = z_q;
  assign overflow   = ov_q;
endmodule

// File: tb/tb_sub64_iterative.sv
module tb_sub64_iterative;
  logic        clk, rst_n, in_valid, in_ready, borrow_in;
  logic        out_valid, out_ready, borrow_out, zero, overflow;
  logic [63:0] A, B, D;
  int passed = 0;
  int total  = 0;

  sub64_iterative dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .borrow_in(borrow_in), .out_valid(out_valid),
    .out_ready(out_ready), .D(D), .borrow_out(borrow_out), .zero(zero),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Present operands, accept on the next edge, then count edges until out_valid.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic bi,
                        output int lat);
    @(negedge clk);
    A = a; B = b; borrow_in = bi; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({in_ready, out_valid, D, borrow_out, zero, overflow} !== {1'b1, 1'b0, 64'd0, 3'b000}) begin
      $display("FAIL reset: in_ready=%b out_valid=%b D=%h bo=%b z=%b ov=%b, want 1 0 0 0 0 0",
               in_ready, out_valid, D, borrow_out, zero, overflow);
    end else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic [63:0] va [7], vb [7], vd [7];
    logic        vbi[7], vbo[7], vz[7], vov[7];
    logic [63:0] d;
    logic        bo, z, ov;
    int lat;
    va[0]=64'd5;                  vb[0]=64'd3;                  vbi[0]=0; vd[0]=64'd2;                  vbo[0]=0; vz[0]=0; vov[0]=0;
    va[1]=64'd0;                  vb[1]=64'd1;                  vbi[1]=0; vd[1]=64'hFFFF_FFFF_FFFF_FFFF; vbo[1]=1; vz[1]=0; vov[1]=0;
    va[2]=64'h8000_0000_0000_0000; vb[2]=64'h8000_0000_0000_0000; vbi[2]=1; vd[2]=64'hFFFF_FFFF_FFFF_FFFF; vbo[2]=1; vz[2]=0; vov[2]=0;
    va[3]=64'h0000_0000_0001_0000; vb[3]=64'd1;                  vbi[3]=0; vd[3]=64'h0000_0000_0000_FFFF; vbo[3]=0; vz[3]=0; vov[3]=0;
    va[4]=64'h1234_5678_9ABC_DEF0; vb[4]=64'h1234_5678_9ABC_DEF0; vbi[4]=0; vd[4]=64'd0;                  vbo[4]=0; vz[4]=1; vov[4]=0;
    va[5]=64'h8000_0000_0000_0000; vb[5]=64'd1;                  vbi[5]=0; vd[5]=64'h7FFF_FFFF_FFFF_FFFF; vbo[5]=0; vz[5]=0; vov[5]=1;
    va[6]=64'd0;                  vb[6]=64'h8000_0000_0000_0000; vbi[6]=0; vd[6]=64'h8000_0000_0000_0000; vbo[6]=1; vz[6]=0; vov[6]=1;
    for (int i = 0; i < 7; i++) begin
      run_op(va[i], vb[i], vbi[i], lat);
      d = D; bo = borrow_out; z = zero; ov = overflow;
      total++;
      if (lat !== 4) $display("FAIL vec%0d latency: got %0d want 4", i, lat);
      else passed++;
      total++;
      if (d !== vd[i]) $display("FAIL vec%0d D: got %h want %h", i, d, vd[i]);
      else passed++;
      total++;
      if ({bo, z, ov} !== {vbo[i], vz[i], vov[i]})
        $display("FAIL vec%0d flags bo/z/ov: got %b%b%b want %b%b%b", i, bo, z, ov, vbo[i], vz[i], vov[i]);
      else passed++;
      finish_op();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(64'h0000_0000_0001_0000, 64'd1, 1'b0, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; A = 64'(i * 7 + 3); B = 64'd0;
      @(posedge clk); #1;
      total++;
      if ({out_valid, in_ready, D, borrow_out, zero, overflow} !==
          {1'b1, 1'b0, 64'h0000_0000_0000_FFFF, 3'b000})
        $display("FAIL hold%0d: ov_valid=%b in_ready=%b D=%h flags=%b%b%b want 1 0 ffff 000",
                 i, out_valid, in_ready, D, borrow_out, zero, overflow);
      else passed++;
    end
    // Result handshake with in_valid held: no accept in the same cycle.
    @(negedge clk);
    out_ready = 1'b1; A = 64'd100; B = 64'd1; borrow_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL handshake: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    else passed++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0) $display("FAIL reaccept: in_ready=%b want 0", in_ready);
    else passed++;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (lat !== 4 || D !== 64'd99)
      $display("FAIL post_bp: lat=%0d D=%h want 4 and 63", lat, D);
    else passed++;
    finish_op();
  endtask

  task automatic test_mid_reset();
    int lat;
    @(negedge clk);
    A = 64'hFFFF_FFFF_FFFF_FFFF; B = 64'd1; borrow_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, in_ready, D} !== {1'b0, 1'b1, 64'd0})
      $display("FAIL midreset: out_valid=%b in_ready=%b D=%h want 0 1 0", out_valid, in_ready, D);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(64'd5, 64'd3, 1'b0, lat);
    total++;
    if (lat !== 4 || D !== 64'd2 || borrow_out !== 1'b0)
      $display("FAIL after_reset: lat=%0d D=%h bo=%b want 4 2 0", lat, D, borrow_out);
    else passed++;
    finish_op();
    total++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL final_idle: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    else passed++;
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; borrow_in = 1'b0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sub64_iterative.md
# sub64_iterative

Multi-cycle unsigned 64-bit subtractor that computes A − B − borrow_in one 16-bit slice per clock, reusing a single borrow-lookahead slice. It is the inverse-direction companion to the team's hierarchical 64-bit lookahead adder. It sits behind a valid/ready handshake, so datapath blocks can trade area for latency when subtracting wide operands.

## Interface
Parameters:
- N, 64, operand/result width; must be a multiple of SLICE, with N/SLICE ≥ 2
- SLICE, 16, bits processed per cycle; must be a multiple of 4

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands (high only in IDLE)
- A  in  N  minuend, unsigned
- B  in  N  subtrahend, unsigned
- borrow_in  in  1  incoming borrow
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- D  out  N  difference, A − B − borrow_in mod 2^N
- borrow_out  out  1  1 iff A < B + borrow_in (unsigned)
- zero  out  1  D == 0
- overflow  out  1  two's-complement overflow: (A[N-1] ≠ B[N-1]) & (D[N-1] ≠ A[N-1])

## Operation
- FSM states and transitions:
  - IDLE: on in_valid & in_ready, latch A, B and borrow_in; clear the slice counter; go to RUN.
  - RUN: each cycle, compute slice k = cnt from latched A, B and the borrow register. Write d into D[k*SLICE +: SLICE] and bout into the borrow register. Increment cnt. When cnt == N/SLICE−1, go to DONE.
  - DONE: out_valid = 1. On out_ready, go to IDLE.
- A new operand is never accepted in the same cycle as a result handshake.
- Slice arithmetic: d = a + ~b + ~bin, computed with 4-bit carry-lookahead groups; bout = ~carry_out.
- Flags are registered on the final RUN cycle:
  - borrow_out = final borrow.
  - zero = all slices zero (accumulate per slice; no N-wide reduction of D).
  - overflow uses the final slice MSBs.
- D, borrow_out, zero and overflow change only in RUN and are held stable throughout DONE.
- Their values outside DONE are don't-care to the consumer.
- Reset (any time, including mid-RUN or in DONE):
  - State goes to IDLE; the partial result is discarded.
  - out_valid = 0, D = 0, borrow_out = 0, zero = 0, overflow = 0, counter = 0.
  - in_ready = 1 (decoded from IDLE).
- in_valid while not in IDLE is ignored. Input buses are sampled only at the accept edge.

## Timing
- Accept edge E0. Slice computations occur at edges E1..E(N/SLICE).
- out_valid rises after edge E(N/SLICE): 4 cycles after accept at default parameters.
- If out_ready is high when out_valid rises, the handshake completes at the next edge and in_ready returns 1 the following cycle.
- Minimum issue interval: N/SLICE + 2 cycles (6 at default).
- out_valid and D are held indefinitely under backpressure.
- in_ready and out_valid are never high in the same cycle.
- All outputs are registered except in_ready, which is a pure decode of state.

## Structure
- Shared package arith_pkg holds:
  - state encoding constants (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2)
  - SLICE_DEFAULT, NUM_SLICES = N/SLICE
  - counter width = clog2(NUM_SLICES)
- Sub-module sub_slice_bla: combinational SLICE-bit borrow-lookahead subtractor.
  - Inputs: a, b, bin.
  - Outputs: d, bout, plus group P/G.
  - Built from the existing 4-bit lookahead cells and 4-group carry generator.
- Top level contains the FSM, slice counter, operand registers, borrow register, result register and flag logic.

## Test plan
- A=5, B=3, borrow_in=0 -> D=2, borrow_out=0, zero=0, overflow=0; out_valid exactly 4 cycles after accept.
- A=0, B=1 -> D=0xFFFF_FFFF_FFFF_FFFF, borrow_out=1. A=B=0x8000_0000_0000_0000 with borrow_in=1 -> D=all ones, borrow_out=1.
- Cross-slice borrow: A=0x0000_0000_0001_0000, B=1 -> D=0x0000_0000_0000_FFFF, borrow_out=0. A=B=0x1234_5678_9ABC_DEF0 -> D=0, zero=1.
- A=0x8000_0000_0000_0000, B=1 -> D=0x7FFF_FFFF_FFFF_FFFF, overflow=1, borrow_out=0.
- Backpressure: out_ready=0 for 10 cycles with in_valid=1 and changing A -> D and flags stable, in_ready=0, no extra accept. out_ready=1 -> IDLE next cycle, then one new accept.
- Assert rst_n=0 mid-RUN at slice 2 -> out_valid=0 and in_ready=1 immediately. After release, 5−3 completes correctly with the 4-cycle latency.
